// File: rtl/bus_pkg.sv
// Shared definitions for the serial bus master port: FSM states, default widths, mode codes.
// Latency: none (definitions only).
// Backpressure: none (definitions only).
package bus_pkg;

   localparam int DEF_ADDR_WIDTH = 12;
   localparam int DEF_DATA_WIDTH = 8;

   localparam logic READ  = 1'b0;
   localparam logic WRITE = 1'b1;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      REQ   = 3'd1,
      ADDR  = 3'd2,
      WDATA = 3'd3,
      RWAIT = 3'd4,
      SPLIT = 3'd5,
      SREQ  = 3'd6,
      DONE  = 3'd7
   } state_t;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/shift_reg.sv
// LSB-first serial register: parallel load, bit-indexed serial out (PISO) and serial in (SIPO).
// Latency: one cycle per bit; sout reflects q[cnt] combinationally.
// Backpressure: caller holds en low to stall; the counter and contents then hold.
//
// Ports: load/din parallel load (also zeroes cnt); clr zeroes cnt only; en advances cnt;
//        wr with en writes sin into q[cnt]; q parallel contents; sout = q[cnt]; cnt bit index.
module shift_reg #(
   parameter int W  = 8,
   parameter int CW = 3
) (
   input  logic          clk,
   input  logic          rstn,
   input  logic          load,
   input  logic [W-1:0]  din,
   input  logic          clr,
   input  logic          en,
   input  logic          wr,
   input  logic          sin,
   output logic [W-1:0]  q,
   output logic          sout,
   output logic [CW-1:0] cnt
);

   // One-hot select of the current bit; the index is never a literal slice.
   logic [W-1:0] sel;
   assign sel  = W'(1) << cnt;
   assign sout = |(q & sel);

   always_ff @(posedge clk) begin
      if (!rstn) begin
         q   <= '0;
         cnt <= '0;
      end else begin
         // The final serial-in bit lands on the same edge the counter is cleared,
         // so the data write is kept independent of clr.
         if (load)
            q <= din;
         else if (en && wr)
            q <= sin ? (q | sel) : (q & ~sel);

         if (load || clr)
            cnt <= '0;
         else if (en)
            cnt <= cnt + CW'(1);
      end
   end

endmodule

// File: rtl/master_port.sv
// Bus master port: takes one local read/write, requests the arbiter, shifts address/write data
// out LSB first and gathers serial read data; handles split release/re-request and lost grant.
// Latency: write ack = accept + 2 + ADDR_WIDTH + DATA_WIDTH + grant latency; read ack one cycle
// after the last mrvalid bit. Backpressure: mready low stalls shifting (mvalid=0, bit held);
// dready is high only in IDLE.
//
// Ports: dvalid/dready/dmode/daddr/dwdata local request, drdata/ack/err completion;
//        breq/bgrant/msplit arbiter handshake; mready/mvalid/mwdata/mmode serial out;
//        mrdata/mrvalid serial read in.
// Optional: define MASTER_TIMEOUT_EN to abort a read after TIMEOUT idle cycles (ack with err=1).
module master_port
   import bus_pkg::*;
#(
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int TIMEOUT    = 255
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic                  dvalid,
   output logic                  dready,
   input  logic                  dmode,
   input  logic [ADDR_WIDTH-1:0] daddr,
   input  logic [DATA_WIDTH-1:0] dwdata,
   output logic [DATA_WIDTH-1:0] drdata,
   output logic                  ack,
   output logic                  err,
   output logic                  breq,
   input  logic                  bgrant,
   input  logic                  msplit,
   input  logic                  mready,
   output logic                  mvalid,
   output logic                  mwdata,
   output logic                  mmode,
   input  logic                  mrdata,
   input  logic                  mrvalid
);

   localparam int              MAXW      = max_int(ADDR_WIDTH, DATA_WIDTH);
   localparam int              CW        = $clog2(MAXW);
   localparam logic [CW-1:0]   ADDR_LAST = CW'(ADDR_WIDTH - 1);
   localparam logic [CW-1:0]   DATA_LAST = CW'(DATA_WIDTH - 1);

   state_t                  state, state_n;
   logic                    mode_q;
   logic [ADDR_WIDTH-1:0]   addr_q;
   logic [DATA_WIDTH-1:0]   data_q;
   logic [DATA_WIDTH-1:0]   drdata_q;
   logic [MAXW-1:0]         sr_q, sr_din;
   logic [CW-1:0]           cnt;
   logic                    sr_sout, sr_load, sr_clr;
   logic                    shifting, tx_bit, rx_bit, tmo;
   logic                    unused_sr;

   assign shifting = (state == ADDR) || (state == WDATA);
   assign tx_bit   = shifting && mready && bgrant;
   assign rx_bit   = (state == RWAIT) && mrvalid;

`ifdef MASTER_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT + 1);
   logic [TW-1:0] tcnt;
   logic          err_q;
   logic          waiting;

   assign waiting = ((state == RWAIT) || (state == SREQ)) && !mrvalid;
   assign tmo     = waiting && (tcnt == TW'(TIMEOUT - 1));
   assign err     = err_q;

   always_ff @(posedge clk) begin
      if (!rstn) begin
         tcnt  <= '0;
         err_q <= 1'b0;
      end else begin
         tcnt  <= waiting ? tcnt + TW'(1) : '0;
         err_q <= tmo;   // tmo always forces DONE, so err lines up with ack
      end
   end
`else
   logic unused_timeout;
   assign unused_timeout = (TIMEOUT != 0);
   assign tmo            = 1'b0;
   assign err            = 1'b0;
`endif

   // Next state.
   always_comb begin
      state_n = state;
      case (state)
         IDLE:  if (dvalid) state_n = REQ;
         REQ:   if (bgrant) state_n = ADDR;
         ADDR: begin
            if (!bgrant)
               state_n = REQ;
            else if (tx_bit && cnt == ADDR_LAST)
               state_n = (mode_q == WRITE) ? WDATA : RWAIT;
         end
         WDATA: begin
            if (!bgrant)
               state_n = REQ;
            else if (tx_bit && cnt == DATA_LAST)
               state_n = DONE;
         end
         RWAIT: begin
            // A split is honoured only before the first read bit arrives.
            if (tmo)
               state_n = DONE;
            else if (msplit && cnt == '0)
               state_n = SPLIT;
            else if (!bgrant)
               state_n = REQ;
            else if (rx_bit && cnt == DATA_LAST)
               state_n = DONE;
         end
         SPLIT: if (!bgrant) state_n = SREQ;
         SREQ: begin
            if (tmo)
               state_n = DONE;
            else if (bgrant)
               state_n = RWAIT;
         end
         DONE:    state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   // Every state change zeroes the bit counter; entering a shift state also reloads
   // the register, which restarts the address from bit 0 after a lost grant.
   assign sr_clr  = (state_n != state);
   assign sr_load = sr_clr && ((state_n == ADDR) || (state_n == WDATA) || (state_n == RWAIT));

   always_comb begin
      sr_din = '0;
      if (state_n == ADDR)
         sr_din = MAXW'(addr_q);
      else if (state_n == WDATA)
         sr_din = MAXW'(data_q);
   end

   shift_reg #(.W(MAXW), .CW(CW)) u_sr (
      .clk  (clk),
      .rstn (rstn),
      .load (sr_load),
      .din  (sr_din),
      .clr  (sr_clr),
      .en   (tx_bit || rx_bit),
      .wr   (rx_bit),
      .sin  (mrdata),
      .q    (sr_q),
      .sout (sr_sout),
      .cnt  (cnt)
   );

   assign unused_sr = ^sr_q;

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state    <= IDLE;
         mode_q   <= READ;
         addr_q   <= '0;
         data_q   <= '0;
         drdata_q <= '0;
      end else begin
         state    <= state_n;
         drdata_q <= drdata;
         if (state == IDLE && dvalid) begin
            mode_q <= dmode;
            addr_q <= daddr;
            data_q <= dwdata;
         end
      end
   end

   // Read data is presented straight from the shift register in DONE and then held.
   always_comb begin
      drdata = drdata_q;
      if (state == DONE) begin
         if (err)
            drdata = '0;
         else if (mode_q == READ)
            drdata = sr_q[DATA_WIDTH-1:0];
      end
   end

   assign dready = (state == IDLE);
   assign ack    = (state == DONE);
   assign breq   = state inside {REQ, ADDR, WDATA, RWAIT, SREQ};
   assign mvalid = tx_bit;
   assign mwdata = shifting && sr_sout;
   assign mmode  = mode_q && (state inside {ADDR, WDATA, RWAIT, SPLIT, SREQ, DONE});

endmodule

// File: tb/tb_master_port.sv
module tb_master_port;
   import bus_pkg::*;

   localparam int AW = 12;
   localparam int DW = 8;

   logic          clk = 1'b0;
   logic          rstn;
   logic          dvalid, dready, dmode;
   logic [AW-1:0] daddr;
   logic [DW-1:0] dwdata, drdata;
   logic          ack, err, breq, bgrant, msplit, mready;
   logic          mvalid, mwdata, mmode, mrdata, mrvalid;

   always #5 clk = ~clk;

   master_port #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(255)) dut (
      .clk(clk), .rstn(rstn), .dvalid(dvalid), .dready(dready), .dmode(dmode),
      .daddr(daddr), .dwdata(dwdata), .drdata(drdata), .ack(ack), .err(err),
      .breq(breq), .bgrant(bgrant), .msplit(msplit), .mready(mready),
      .mvalid(mvalid), .mwdata(mwdata), .mmode(mmode), .mrdata(mrdata), .mrvalid(mrvalid)
   );

   typedef struct {
      logic [DW-1:0] rdata;
      logic          err;
   } exp_t;

   int      n_vec = 0;
   int      n_bad = 0;
   int      cyc   = 0;
   int      ack_cnt = 0;
   int      ack_cyc = 0;
   int      acc_cyc = 0;
   logic    exp_mode = 1'b0;
   logic [DW-1:0] exp_rd = '0;
   logic    bit_q[$];
   exp_t    txn_q[$];
   exp_t    mon_e;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // Arbiter stand-in: grants one cycle after seeing a request, drops one cycle after release.
   initial begin
      logic r;
      bgrant = 1'b0;
      forever begin
         @(negedge clk);
         r = breq;
         @(posedge clk);
         #1 bgrant = r;
      end
   end

   // Monitor: serial bits and completions against the scoreboard.
   initial forever begin
      @(negedge clk);
      if (rstn) begin
         if (mvalid) begin
            check_eq("mmode", mmode, exp_mode);
            if (bit_q.size() == 0)
               check_eq("mwdata_extra_bit", 32'(bit_q.size()), 1);
            else
               check_eq("mwdata", mwdata, bit_q.pop_front());
         end
         if (ack) begin
            ack_cnt++;
            ack_cyc = cyc;
            check_eq("breq_in_ack", breq, 0);
            if (txn_q.size() == 0)
               check_eq("ack_unexpected", 32'(txn_q.size()), 1);
            else begin
               mon_e = txn_q.pop_front();
               check_eq("drdata", drdata, mon_e.rdata);
               check_eq("err", err, mon_e.err);
            end
         end
      end
   end

   task automatic check_reset_outputs();
      check_eq("rst_dready", dready, 1);
      check_eq("rst_breq",   breq,   0);
      check_eq("rst_mvalid", mvalid, 0);
      check_eq("rst_mwdata", mwdata, 0);
      check_eq("rst_mmode",  mmode,  0);
      check_eq("rst_ack",    ack,    0);
      check_eq("rst_err",    err,    0);
      check_eq("rst_drdata", drdata, 0);
   endtask

   // Issue one request; scoreboard gets the serial bits and the completion it implies.
   task automatic send(input logic mode, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input logic [DW-1:0] rd, input logic e);
      exp_t t;
      for (int i = 0; i < 50 && !dready; i++) begin
         @(posedge clk);
         #1;
      end
      check_eq("dready_before_send", dready, 1);
      exp_mode = mode;
      for (int i = 0; i < AW; i++) bit_q.push_back(a[i]);
      if (mode == WRITE)
         for (int i = 0; i < DW; i++) bit_q.push_back(d[i]);
      if (mode == READ && !e) exp_rd = rd;
      if (e) exp_rd = '0;
      t.rdata = (mode == WRITE) ? exp_rd : (e ? '0 : rd);
      t.err   = e;
      txn_q.push_back(t);
      dvalid = 1'b1; dmode = mode; daddr = a; dwdata = d;
      acc_cyc = cyc;
      @(posedge clk);
      #1;
      dvalid = 1'b0;
      check_eq("breq_after_accept", breq, 1);
   endtask

   task automatic wait_ack(input int target, input int bound);
      for (int i = 0; i < bound && ack_cnt < target; i++) begin
         @(negedge clk);
         #1;
      end
      check_eq("ack_wait", ack_cnt, target);
   endtask

   // Returns in the first RWAIT cycle, just after the address phase.
   task automatic wait_addr_done();
      for (int i = 0; i < 200 && bit_q.size() != 0; i++) begin
         @(negedge clk);
         #1;
      end
      check_eq("addr_phase_done", 32'(bit_q.size()), 0);
      @(posedge clk);
      #1;
   endtask

   task automatic drive_rdata(input logic [DW-1:0] v);
      for (int i = 0; i < DW; i++) begin
         mrvalid = 1'b1;
         mrdata  = v[i];
         @(posedge clk);
         #1;
      end
      mrvalid = 1'b0;
      mrdata  = 1'b0;
   endtask

   initial begin
      int base;
      rstn = 1'b0; dvalid = 1'b0; dmode = 1'b0; daddr = '0; dwdata = '0;
      msplit = 1'b0; mready = 1'b1; mrdata = 1'b0; mrvalid = 1'b0;
      repeat (3) @(posedge clk);
      #1 rstn = 1'b1;
      @(negedge clk);
      check_reset_outputs();

      // Plain write, grant one cycle after request: ack 23 cycles after the accept cycle.
      @(posedge clk); #1;
      send(WRITE, 12'h5A3, 8'hC4, 8'h00, 1'b0);
      wait_ack(1, 60);
      check_eq("wr_latency", ack_cyc - acc_cyc, 23);
      repeat (4) @(negedge clk);
      check_eq("wr_single_ack", ack_cnt, 1);

      // Read: slave returns 0x96.
      send(READ, 12'h010, 8'h00, 8'h96, 1'b0);
      wait_addr_done();
      drive_rdata(8'h96);
      wait_ack(2, 5);

      // Backpressure: mready low for three cycles after address bit 4.
      send(WRITE, 12'h0F0, 8'h5A, 8'h00, 1'b0);
      for (int i = 0; i < 60 && bit_q.size() > 15; i++) begin
         @(negedge clk);
         #1;
      end
      @(posedge clk); #1;
      mready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check_eq("bp_mvalid_low", mvalid, 0);
         check_eq("bp_held_bit", mwdata, bit_q[0]);
         @(posedge clk); #1;
      end
      mready = 1'b1;
      wait_ack(3, 60);
      check_eq("bp_latency", ack_cyc - acc_cyc, 26);

      // Split before the first read bit, then regrant and deliver 0x3F.
      send(READ, 12'h2A5, 8'h00, 8'h3F, 1'b0);
      wait_addr_done();
      msplit = 1'b1;
      @(posedge clk); #1;
      msplit = 1'b0;
      @(negedge clk);
      check_eq("split_breq_low", breq, 0);
      @(negedge clk);
      check_eq("split_wait_breq", breq, 0);
      check_eq("split_grant_gone", bgrant, 0);
      @(negedge clk);
      check_eq("sreq_breq_high", breq, 1);
      for (int i = 0; i < 20 && !bgrant; i++) @(negedge clk);
      check_eq("sreq_regrant", bgrant, 1);
      @(posedge clk); #1;
      drive_rdata(8'h3F);
      wait_ack(4, 5);

      // Reset during data bit 4 of a write: no ack, everything back to reset values.
      send(WRITE, 12'h123, 8'hE7, 8'h00, 1'b0);
      for (int i = 0; i < 60 && bit_q.size() > 4; i++) begin
         @(negedge clk);
         #1;
      end
      @(posedge clk); #1;
      rstn = 1'b0;
      bit_q.delete();
      txn_q.delete();
      exp_rd = '0;
      base = ack_cnt;
      @(posedge clk); #1;
      rstn = 1'b1;
      @(negedge clk);
      check_reset_outputs();
      repeat (30) @(negedge clk);
      check_eq("no_ack_after_reset", ack_cnt, base);

      // Recovery write; held read data must now be the reset value.
      send(WRITE, 12'h7FF, 8'h81, 8'h00, 1'b0);
      wait_ack(base + 1, 60);

`ifdef MASTER_TIMEOUT_EN
      // No read bits at all: abort with err and zero data.
      send(READ, 12'h0AA, 8'h00, 8'h00, 1'b1);
      wait_ack(base + 2, 400);
`endif

      repeat (2) @(negedge clk);
      check_eq("scoreboard_drained", 32'(txn_q.size() + bit_q.size()), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
